// File: rtl/booth_radix4_encoder_if.sv
// Operand, handshake and partial-product bundle between the Booth encoder
// and its producer/consumer.
interface booth_radix4_encoder_if #(
    parameter int length = 32
);
    logic              start;
    logic [length-1:0] multiplicand;
    logic [length-1:0] multiplier;
    logic              op_in;
    logic              result_ack;
    logic              flush;
    logic              busy;
    logic              enable_mult;
    logic              operation;
    logic [length:0]   partial1_booth;
    logic [length:0]   partial2_booth;
    logic [length:0]   partial3_booth;
    logic [length:0]   partial4_booth;
    logic [length:0]   partial5_booth;
    logic [length:0]   partial6_booth;
    logic [length:0]   partial7_booth;
    logic [length:0]   partial8_booth;
    logic [length:0]   partial9_booth;
    logic [length:0]   partial10_booth;
    logic [length:0]   partial11_booth;
    logic [length:0]   partial12_booth;
    logic [length:0]   partial13_booth;
    logic [length:0]   partial14_booth;
    logic [length:0]   partial15_booth;
    logic [length:0]   partial16_booth;

    modport master (
        output start, multiplicand, multiplier, op_in, result_ack, flush,
        input  busy, enable_mult, operation,
        input  partial1_booth, partial2_booth, partial3_booth, partial4_booth,
        input  partial5_booth, partial6_booth, partial7_booth, partial8_booth,
        input  partial9_booth, partial10_booth, partial11_booth, partial12_booth,
        input  partial13_booth, partial14_booth, partial15_booth, partial16_booth
    );

    modport slave (
        input  start, multiplicand, multiplier, op_in, result_ack, flush,
        output busy, enable_mult, operation,
        output partial1_booth, partial2_booth, partial3_booth, partial4_booth,
        output partial5_booth, partial6_booth, partial7_booth, partial8_booth,
        output partial9_booth, partial10_booth, partial11_booth, partial12_booth,
        output partial13_booth, partial14_booth, partial15_booth, partial16_booth
    );
endinterface

// File: rtl/booth_radix4_encoder.sv
// Radix-4 Booth front end: captures operands, recodes the multiplier with one
// shared 8-digit recoder over two cycles, and holds the 16 partials until acked.
module booth_radix4_encoder #(
    parameter int length = 32
) (
    input logic                  clk,
    input logic                  rst_n,
    booth_radix4_encoder_if.slave bus
);
    localparam int DIGITS = length / 2;
    localparam int HALF   = DIGITS / 2;
    localparam int PP_W   = length + 1;
    localparam logic signed [PP_W-1:0] PP_ONE = PP_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENC_LO = 2'd1,
        ENC_HI = 2'd2,
        VALID  = 2'd3
    } state_t;

    state_t                   r_state;
    logic signed [length-1:0] r_a;
    logic        [length-1:0] r_b;
    logic                     r_op;
    logic                     r_busy;
    logic                     r_enable;
    logic signed [PP_W-1:0]   r_pp [DIGITS];

    logic                     w_hi;
    logic        [length:0]   w_b_ext;
    logic signed [PP_W-1:0]   w_a_ext;
    logic        [2:0]        w_trip [HALF];
    logic signed [PP_W-1:0]   w_pp   [HALF];

    // Booth digit applied to the sign-extended multiplicand, modulo 2^PP_W.
    function automatic logic signed [PP_W-1:0] booth_pp(
        input logic        [2:0]      trip,
        input logic signed [PP_W-1:0] a_ext
    );
        logic signed [PP_W-1:0] mag;
        logic                   neg;
        case (trip)
            3'b001, 3'b010, 3'b101, 3'b110: mag = a_ext;
            3'b011, 3'b100:                 mag = a_ext <<< 1;
            default:                        mag = '0;
        endcase
        neg = trip[2] & ~(trip[1] & trip[0]);
        booth_pp = neg ? (~mag + PP_ONE) : mag;
    endfunction

    // Recode stage: B_r[-1] is the appended zero, so triplet k starts at bit 2k.
    assign w_hi    = (r_state == ENC_HI);
    assign w_b_ext = {r_b, 1'b0};
    assign w_a_ext = {r_a[length-1], r_a};

    for (genvar j = 0; j < HALF; j++) begin : g_recoder
        assign w_trip[j] = w_hi ? w_b_ext[2*(j+HALF) +: 3] : w_b_ext[2*j +: 3];
        assign w_pp[j]   = booth_pp(w_trip[j], w_a_ext);
    end

    // Control and partial-product registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= 1'b0;
            r_busy   <= 1'b0;
            r_enable <= 1'b0;
            for (int i = 0; i < DIGITS; i++) r_pp[i] <= '0;
        end else if (bus.flush) begin
            r_state  <= IDLE;
            r_op     <= 1'b0;
            r_busy   <= 1'b0;
            r_enable <= 1'b0;
            for (int i = 0; i < DIGITS; i++) r_pp[i] <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_a     <= bus.multiplicand;
                        r_b     <= bus.multiplier;
                        r_op    <= bus.op_in;
                        r_busy  <= 1'b1;
                        r_state <= ENC_LO;
                    end
                end
                ENC_LO: begin
                    for (int j = 0; j < HALF; j++) r_pp[j] <= w_pp[j];
                    r_state <= ENC_HI;
                end
                ENC_HI: begin
                    for (int j = 0; j < HALF; j++) r_pp[j+HALF] <= w_pp[j];
                    r_enable <= 1'b1;
                    r_state  <= VALID;
                end
                VALID: begin
                    if (bus.result_ack) begin
                        r_enable <= 1'b0;
                        if (bus.start) begin
                            r_a     <= bus.multiplicand;
                            r_b     <= bus.multiplier;
                            r_op    <= bus.op_in;
                            r_state <= ENC_LO;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy            = r_busy;
    assign bus.enable_mult     = r_enable;
    assign bus.operation       = r_op;
    assign bus.partial1_booth  = r_pp[0];
    assign bus.partial2_booth  = r_pp[1];
    assign bus.partial3_booth  = r_pp[2];
    assign bus.partial4_booth  = r_pp[3];
    assign bus.partial5_booth  = r_pp[4];
    assign bus.partial6_booth  = r_pp[5];
    assign bus.partial7_booth  = r_pp[6];
    assign bus.partial8_booth  = r_pp[7];
    assign bus.partial9_booth  = r_pp[8];
    assign bus.partial10_booth = r_pp[9];
    assign bus.partial11_booth = r_pp[10];
    assign bus.partial12_booth = r_pp[11];
    assign bus.partial13_booth = r_pp[12];
    assign bus.partial14_booth = r_pp[13];
    assign bus.partial15_booth = r_pp[14];
    assign bus.partial16_booth = r_pp[15];
endmodule
